// File: rtl/ascon_aead_stream.sv
// Streaming ASCON-style AEAD engine: one 64-bit block per handshake, with
// UNROLL permutation rounds per clock and optional decrypt/tag check.
// Input handshake: a block moves when in_valid_i && in_ready_o at a rising
// edge. Output handshake: out_data_o is held while out_valid_o is high and
// is released when out_ready_i is seen high.
module ascon_aead_stream #(
    parameter int UNROLL     = 1,
    parameter int DECRYPT_EN = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [127:0]     key_i,
    input  logic [127:0]     nonce_i,
    input  logic [127:0]     tag_i,
    input  logic             in_valid_i,
    input  logic             in_last_i,
    input  logic             in_is_ad_i,
    input  logic [63:0]      in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [63:0]      out_data_o,
    output logic [127:0]     tag_o,
    output logic             tag_valid_o,
    output logic             auth_ok_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] blk_cnt_o,
    output logic [3:0]       dbg_state_o
);

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6)) begin : g_bad_unroll
            $error("ascon_aead_stream: UNROLL must be 1, 2, 3 or 6");
        end
    endgenerate

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_INIT     = 4'd1;
    localparam logic [3:0] S_WAIT_AD  = 4'd2;
    localparam logic [3:0] S_PERM_AD  = 4'd3;
    localparam logic [3:0] S_WAIT_MSG = 4'd4;
    localparam logic [3:0] S_OUT_HOLD = 4'd5;
    localparam logic [3:0] S_PERM_MSG = 4'd6;
    localparam logic [3:0] S_FINAL    = 4'd7;
    localparam logic [3:0] S_TAG      = 4'd8;

    localparam logic [3:0]  STEP = 4'(UNROLL);
    localparam logic [63:0] IV   = 64'h80400c0600000000;

    logic [3:0]   st;
    logic [319:0] s;          // {x0, x1, x2, x3, x4}, x0 is the rate word
    logic [3:0]   rnd;        // index of the next round to apply
    logic [127:0] key_r;
    logic [127:0] tag_r;
    logic         mode_r;
    logic         ad_last;
    logic         msg_last;
    logic [319:0] perm_s;
    logic         perm_last;
    logic [127:0] tag_calc;

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // One round: constant on x2, bitsliced 5-bit S-box, per-word diffusion.
    function automatic logic [319:0] ascon_round(input logic [319:0] si, input logic [3:0] r);
        logic [63:0] a0, a1, a2, a3, a4;
        logic [63:0] t0, t1, t2, t3, t4;
        {a0, a1, a2, a3, a4} = si;
        a2 = a2 ^ {56'h0, 8'hF0 - (8'(r) * 8'h0F)};
        a0 = a0 ^ a4; a4 = a4 ^ a3; a2 = a2 ^ a1;
        t0 = ~a0 & a1; t1 = ~a1 & a2; t2 = ~a2 & a3; t3 = ~a3 & a4; t4 = ~a4 & a0;
        a0 = a0 ^ t1; a1 = a1 ^ t2; a2 = a2 ^ t3; a3 = a3 ^ t4; a4 = a4 ^ t0;
        a1 = a1 ^ a0; a0 = a0 ^ a4; a3 = a3 ^ a2; a2 = ~a2;
        a0 = a0 ^ ror(a0, 19) ^ ror(a0, 28);
        a1 = a1 ^ ror(a1, 61) ^ ror(a1, 39);
        a2 = a2 ^ ror(a2, 1)  ^ ror(a2, 6);
        a3 = a3 ^ ror(a3, 10) ^ ror(a3, 17);
        a4 = a4 ^ ror(a4, 7)  ^ ror(a4, 41);
        return {a0, a1, a2, a3, a4};
    endfunction

    // Chain UNROLL rounds starting at the current round index.
    always_comb begin
        perm_s = s;
        for (int i = 0; i < UNROLL; i++) begin
            perm_s = ascon_round(perm_s, rnd + 4'(i));
        end
    end

    assign perm_last   = (rnd + STEP) == 4'd12;
    assign tag_calc    = perm_s[127:0] ^ key_r;
    assign in_ready_o  = ((st == S_WAIT_AD && in_is_ad_i) || st == S_WAIT_MSG) && !out_valid_o;
    assign busy_o      = st != S_IDLE;
    assign dbg_state_o = st;

    // Control FSM and datapath state; each permutation state loops until the round index reaches 12.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            st          <= S_IDLE;
            s           <= '0;
            rnd         <= '0;
            key_r       <= '0;
            tag_r       <= '0;
            mode_r      <= 1'b0;
            ad_last     <= 1'b0;
            msg_last    <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            tag_o       <= '0;
            tag_valid_o <= 1'b0;
            auth_ok_o   <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            blk_cnt_o   <= '0;
        end else begin
            done_o <= 1'b0;
            case (st)
                S_IDLE: if (start_i) begin
                    key_r       <= key_i;
                    tag_r       <= tag_i;
                    mode_r      <= (DECRYPT_EN != 0) ? mode_i : 1'b0;
                    s           <= {IV, key_i, nonce_i};
                    err_o       <= 1'b0;
                    blk_cnt_o   <= '0;
                    tag_valid_o <= 1'b0;
                    auth_ok_o   <= 1'b0;
                    rnd         <= 4'd0;
                    st          <= S_INIT;
                end
                S_INIT: begin
                    s   <= perm_last ? (perm_s ^ {192'h0, key_r}) : perm_s;
                    rnd <= rnd + STEP;
                    if (perm_last) st <= S_WAIT_AD;
                end
                S_WAIT_AD: begin
                    if (in_valid_i && in_is_ad_i) begin
                        s[319:256] <= s[319:256] ^ in_data_i;
                        ad_last    <= in_last_i;
                        rnd        <= 4'd6;
                        st         <= S_PERM_AD;
                    end else if (in_valid_i) begin
                        // no associated data: domain separation only, block waits for WAIT_MSG
                        s[0] <= ~s[0];
                        st   <= S_WAIT_MSG;
                    end
                end
                S_PERM_AD: begin
                    s   <= (perm_last && ad_last) ? (perm_s ^ 320'h1) : perm_s;
                    rnd <= rnd + STEP;
                    if (perm_last) st <= ad_last ? S_WAIT_MSG : S_WAIT_AD;
                end
                S_WAIT_MSG: if (in_valid_i) begin
                    out_data_o <= s[319:256] ^ in_data_i;
                    s[319:256] <= mode_r ? in_data_i : (s[319:256] ^ in_data_i);
                    out_valid_o <= 1'b1;
                    blk_cnt_o   <= blk_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
                    msg_last    <= in_last_i;
                    if (in_is_ad_i) err_o <= 1'b1;
                    st <= S_OUT_HOLD;
                end
                S_OUT_HOLD: if (out_ready_i) begin
                    out_valid_o <= 1'b0;
                    if (msg_last) begin
                        s   <= s ^ {64'h0, key_r, 128'h0};
                        rnd <= 4'd0;
                        st  <= S_FINAL;
                    end else begin
                        rnd <= 4'd6;
                        st  <= S_PERM_MSG;
                    end
                end
                S_PERM_MSG: begin
                    s   <= perm_s;
                    rnd <= rnd + STEP;
                    if (perm_last) st <= S_WAIT_MSG;
                end
                S_FINAL: begin
                    s   <= perm_s;
                    rnd <= rnd + STEP;
                    if (perm_last) begin
                        tag_o       <= tag_calc;
                        tag_valid_o <= 1'b1;
                        auth_ok_o   <= mode_r ? (tag_calc == tag_r) : 1'b1;
                        done_o      <= 1'b1;
                        st          <= S_TAG;
                    end
                end
                S_TAG:   st <= S_IDLE;
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_aead_stream.sv
// Bench for ascon_aead_stream: four instances (UNROLL 1, 2, 3, 6) share the
// stimulus; only the selected one is started. Expected values come from an
// S-box-table reference model of the construction.
module tb_ascon_aead_stream;

    localparam logic [63:0]  IV = 64'h80400c0600000000;
    localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] N  = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [63:0]  AD = 64'h4153434f4e2d4144;
    localparam logic [63:0]  P0 = 64'h0123456789abcdef;
    localparam logic [63:0]  P1 = 64'hfedcba9876543210;
    localparam logic [3:0]   ST_IDLE = 4'd0, ST_INIT = 4'd1, ST_OUT_HOLD = 4'd5, ST_PERM_MSG = 4'd6;

    typedef struct {
        logic [1:0]   dut;
        logic         dec;
        int           n_ad;
        logic [127:0] tag_in;
        logic [63:0]  d0, d1;
        logic [63:0]  e0, e1;
        logic [127:0] etag;
        logic         eauth;
        int           einit;
        int           elow;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic         start_a [4];
    logic         mode;
    logic [127:0] key, nonce, tag_in;
    logic         in_valid, in_last, in_is_ad, out_ready;
    logic [63:0]  in_data;

    logic         in_ready_a [4], out_valid_a [4], tag_valid_a [4], auth_ok_a [4];
    logic         busy_a [4], done_a [4], err_a [4];
    logic [63:0]  out_data_a [4];
    logic [127:0] tag_a [4];
    logic [15:0]  blk_cnt_a [4];
    logic [3:0]   dbg_a [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int U = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 6;
        ascon_aead_stream #(.UNROLL(U), .DECRYPT_EN(1), .CNT_W(16)) dut (
            .clock_i(clk), .reset_i(rst), .start_i(start_a[g]), .mode_i(mode),
            .key_i(key), .nonce_i(nonce), .tag_i(tag_in),
            .in_valid_i(in_valid), .in_last_i(in_last), .in_is_ad_i(in_is_ad),
            .in_data_i(in_data), .in_ready_o(in_ready_a[g]),
            .out_valid_o(out_valid_a[g]), .out_ready_i(out_ready), .out_data_o(out_data_a[g]),
            .tag_o(tag_a[g]), .tag_valid_o(tag_valid_a[g]), .auth_ok_o(auth_ok_a[g]),
            .busy_o(busy_a[g]), .done_o(done_a[g]), .err_o(err_a[g]),
            .blk_cnt_o(blk_cnt_a[g]), .dbg_state_o(dbg_a[g])
        );
    end

    logic [1:0]   sel;
    logic         in_ready_s, out_valid_s, tag_valid_s, auth_ok_s, busy_s, done_s, err_s;
    logic [63:0]  out_data_s;
    logic [127:0] tag_s;
    logic [15:0]  blk_cnt_s;
    logic [3:0]   dbg_s;

    // view of the selected instance
    always_comb begin
        in_ready_s  = in_ready_a[sel];
        out_valid_s = out_valid_a[sel];
        tag_valid_s = tag_valid_a[sel];
        auth_ok_s   = auth_ok_a[sel];
        busy_s      = busy_a[sel];
        done_s      = done_a[sel];
        err_s       = err_a[sel];
        out_data_s  = out_data_a[sel];
        tag_s       = tag_a[sel];
        blk_cnt_s   = blk_cnt_a[sel];
        dbg_s       = dbg_a[sel];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [4:0] sbox_t [32];

    function automatic logic [63:0] rot(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v} >> n;
        return d[63:0];
    endfunction

    function automatic logic [63:0] lin(input logic [63:0] v, input int a, input int b);
        return v ^ rot(v, a) ^ rot(v, b);
    endfunction

    function automatic logic [319:0] m_round(input logic [319:0] si, input int r);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  v, w;
        for (int i = 0; i < 5; i++) x[i] = si[319-64*i -: 64];
        x[2] = x[2] ^ 64'(240 - 15 * r);
        for (int j = 0; j < 64; j++) begin
            v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
            w = sbox_t[v];
            for (int i = 0; i < 5; i++) y[i][j] = w[4-i];
        end
        return {lin(y[0], 19, 28), lin(y[1], 61, 39), lin(y[2], 1, 6), lin(y[3], 10, 17), lin(y[4], 7, 41)};
    endfunction

    function automatic logic [319:0] m_perm(input logic [319:0] si, input int first);
        logic [319:0] t;
        t = si;
        for (int r = first; r < 12; r++) t = m_round(t, r);
        return t;
    endfunction

    function automatic void model(input logic [127:0] k, input logic [127:0] n, input logic dec,
                                  input int n_ad, input logic [63:0] ad, input logic [63:0] m0,
                                  input logic [63:0] m1, output logic [63:0] o0,
                                  output logic [63:0] o1, output logic [127:0] tg);
        logic [319:0] t;
        logic [63:0]  m, o;
        t = m_perm({IV, k, n}, 0) ^ {192'h0, k};
        if (n_ad > 0) t = m_perm(t ^ {ad, 256'h0}, 6);
        t[0] = ~t[0];
        o0 = '0;
        o1 = '0;
        for (int i = 0; i < 2; i++) begin
            m = (i == 0) ? m0 : m1;
            o = t[319:256] ^ m;
            t[319:256] = dec ? m : o;
            if (i == 0) begin
                o0 = o;
                t = m_perm(t, 6);
            end else begin
                o1 = o;
            end
        end
        t = m_perm(t ^ {64'h0, k, 128'h0}, 0);
        tg = t[127:0] ^ k;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_op(output int n_init);
        @(negedge clk);
        start_a[sel] = 1'b1;
        @(negedge clk);
        start_a[sel] = 1'b0;
        n_init = 0;
        while (dbg_s == ST_INIT && n_init < 100) begin
            n_init++;
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [63:0] d, input logic ad, input logic last, output int low);
        in_data  = d;
        in_is_ad = ad;
        in_last  = last;
        in_valid = 1'b1;
        low = 0;
        #1;
        while (!in_ready_s && low < 200) begin
            low++;
            @(negedge clk);
            #1;
        end
        if (low >= 200) chk("send_timeout", 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        in_is_ad = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        while (!out_valid_s && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) chk(name, 1, 0);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done_s && n < 400) begin
            n++;
            @(negedge clk);
        end
        if (n >= 400) chk(name, 1, 0);
    endtask

    task automatic check_zero(input string name);
        chk(name, {out_valid_s, in_ready_s, busy_s, done_s, err_s, tag_valid_s, auth_ok_s,
                   blk_cnt_s, out_data_s, tag_s}, '0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n_init, low, dummy;
        sel = v.dut; mode = v.dec; key = K; nonce = N; tag_in = v.tag_in;
        out_ready = 1'b1; in_valid = 1'b0;
        start_op(n_init);
        chk($sformatf("v%0d_init_cycles", idx), n_init, v.einit);
        if (v.n_ad > 0) begin
            send(AD, 1'b1, 1'b1, low);
            send(v.d0, 1'b0, 1'b0, dummy);
        end else begin
            send(v.d0, 1'b0, 1'b0, low);
        end
        chk($sformatf("v%0d_first_ready_low", idx), low, v.elow);
        wait_out_valid($sformatf("v%0d_out0_timeout", idx));
        chk($sformatf("v%0d_out0", idx), out_data_s, v.e0);
        send(v.d1, 1'b0, 1'b1, dummy);
        wait_out_valid($sformatf("v%0d_out1_timeout", idx));
        chk($sformatf("v%0d_out1", idx), out_data_s, v.e1);
        wait_done($sformatf("v%0d_done_timeout", idx));
        chk($sformatf("v%0d_tag", idx), tag_s, v.etag);
        chk($sformatf("v%0d_auth_ok", idx), auth_ok_s, v.eauth);
        chk($sformatf("v%0d_tag_valid", idx), tag_valid_s, 1);
        chk($sformatf("v%0d_blk_cnt", idx), blk_cnt_s, 2);
        @(negedge clk);
        chk($sformatf("v%0d_done_one_cycle", idx), done_s, 0);
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs [8];

    initial begin
        logic [63:0]  c0, c1, na0, na1;
        logic [127:0] tg, natg;
        int n, low;

        sbox_t = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                   5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                   5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                   5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
        model(K, N, 1'b0, 1, AD, P0, P1, c0, c1, tg);
        model(K, N, 1'b0, 0, AD, P0, P1, na0, na1, natg);

        vecs[0] = '{dut:2'd0, dec:1'b0, n_ad:1, tag_in:'0, d0:P0, d1:P1, e0:c0, e1:c1, etag:tg, eauth:1'b1, einit:12, elow:0};
        vecs[1] = '{dut:2'd1, dec:1'b0, n_ad:1, tag_in:'0, d0:P0, d1:P1, e0:c0, e1:c1, etag:tg, eauth:1'b1, einit:6, elow:0};
        vecs[2] = '{dut:2'd2, dec:1'b0, n_ad:1, tag_in:'0, d0:P0, d1:P1, e0:c0, e1:c1, etag:tg, eauth:1'b1, einit:4, elow:0};
        vecs[3] = '{dut:2'd3, dec:1'b0, n_ad:1, tag_in:'0, d0:P0, d1:P1, e0:c0, e1:c1, etag:tg, eauth:1'b1, einit:2, elow:0};
        vecs[4] = '{dut:2'd0, dec:1'b1, n_ad:1, tag_in:tg, d0:c0, d1:c1, e0:P0, e1:P1, etag:tg, eauth:1'b1, einit:12, elow:0};
        vecs[5] = '{dut:2'd0, dec:1'b1, n_ad:1, tag_in:tg ^ 128'h1, d0:c0, d1:c1, e0:P0, e1:P1, etag:tg, eauth:1'b0, einit:12, elow:0};
        vecs[6] = '{dut:2'd0, dec:1'b0, n_ad:0, tag_in:'0, d0:P0, d1:P1, e0:na0, e1:na1, etag:natg, eauth:1'b1, einit:12, elow:1};
        vecs[7] = '{dut:2'd3, dec:1'b1, n_ad:0, tag_in:natg, d0:na0, d1:na1, e0:P0, e1:P1, etag:natg, eauth:1'b1, einit:2, elow:1};

        rst = 1'b1; sel = 2'd0; mode = 1'b0; key = '0; nonce = '0; tag_in = '0;
        in_valid = 1'b0; in_last = 1'b0; in_is_ad = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int g = 0; g < 4; g++) start_a[g] = 1'b0;

        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            sel = 2'(g);
            #1;
            check_zero($sformatf("reset_outputs_u%0d", g));
        end
        sel = 2'd0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("idle_after_release");

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // backpressure with an AD-flagged block inside the message phase
        sel = 2'd0; mode = 1'b0; key = K; nonce = N; tag_in = '0; out_ready = 1'b0;
        start_op(n);
        send(AD, 1'b1, 1'b1, low);
        send(P0, 1'b1, 1'b0, low);
        wait_out_valid("bp_out0_timeout");
        chk("bp_out0", out_data_s, c0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_data_%0d", i), out_data_s, c0);
            chk($sformatf("bp_hold_ctrl_%0d", i), {out_valid_s, in_ready_s, dbg_s}, {1'b1, 1'b0, ST_OUT_HOLD});
        end
        chk("bp_err_set", err_s, 1);
        chk("bp_blk_cnt", blk_cnt_s, 1);
        out_ready = 1'b1;
        send(P1, 1'b0, 1'b1, low);
        wait_out_valid("bp_out1_timeout");
        chk("bp_out1", out_data_s, c1);
        wait_done("bp_done_timeout");
        chk("bp_tag", tag_s, tg);
        chk("bp_err_sticky", err_s, 1);

        // new start clears sticky status, then reset lands mid PERM_MSG
        start_op(n);
        chk("restart_init_cycles", n, 12);
        chk("restart_clears", {err_s, tag_valid_s, blk_cnt_s}, '0);
        send(AD, 1'b1, 1'b1, low);
        send(P0, 1'b0, 1'b0, low);
        n = 0;
        while (dbg_s != ST_PERM_MSG && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("perm_msg_timeout", 1, 0);
        #2 rst = 1'b1;
        #1;
        check_zero("reset_mid_perm_outputs");
        chk("reset_mid_perm_state", dbg_s, ST_IDLE);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("after_mid_reset_idle");
        run_vec(vecs[0], 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
